// File: rtl/display_scan_controller.sv
// Scan sequencer for the three-digit 7-segment display: steps the segment
// multiplexer select through digits 0..2 and precedes each lit phase with an all-off guard.
module display_scan_controller #(
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [2:0] MASK,
  output logic       SEL0,
  output logic       SEL1,
  output logic       DIG0,
  output logic       DIG1,
  output logic       DIG2,
  output logic       TICK
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G0   = 3'd1,
    D0   = 3'd2,
    G1   = 3'd3,
    D1   = 3'd4,
    G2   = 3'd5,
    D2   = 3'd6
  } state_t;

  // Select codes are fixed by the multiplexer wiring as {SEL1,SEL0}; 11 blanks it.
  localparam logic [1:0] SEL_DIG0  = 2'b00;
  localparam logic [1:0] SEL_DIG1  = 2'b10;
  localparam logic [1:0] SEL_DIG2  = 2'b01;
  localparam logic [1:0] SEL_BLANK = 2'b11;

  localparam logic [CNT_WIDTH-1:0] ON_LAST    = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_CYCLES - 1);

  state_t               state;
  state_t               next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] next_cnt;

  logic [1:0] sel_q;
  logic [2:0] dig_q;
  logic       tick_q;
  logic [1:0] sel_d;
  logic [2:0] dig_d;
  logic       tick_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= SEL_BLANK;
      dig_q  <= 3'b111;
      tick_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      sel_q  <= sel_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
    end
  end

  // The counter restarts on every state entry, so each phase compares against its own length.
  always_comb begin
    next_state = state;
    next_cnt   = cnt + CNT_WIDTH'(1);
    if (!EN) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          next_state = G0;
          next_cnt   = '0;
        end
        G0: if (cnt == GUARD_LAST) begin
          next_state = D0;
          next_cnt   = '0;
        end
        D0: if (cnt == ON_LAST) begin
          next_state = G1;
          next_cnt   = '0;
        end
        G1: if (cnt == GUARD_LAST) begin
          next_state = D1;
          next_cnt   = '0;
        end
        D1: if (cnt == ON_LAST) begin
          next_state = G2;
          next_cnt   = '0;
        end
        G2: if (cnt == GUARD_LAST) begin
          next_state = D2;
          next_cnt   = '0;
        end
        D2: if (cnt == ON_LAST) begin
          next_state = G0;
          next_cnt   = '0;
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the state being entered so the registers line up with it.
  always_comb begin
    sel_d  = SEL_BLANK;
    dig_d  = 3'b111;
    tick_d = 1'b0;
    case (next_state)
      G0: sel_d = SEL_DIG0;
      D0: begin
        sel_d    = SEL_DIG0;
        dig_d[0] = MASK[0];
      end
      G1: sel_d = SEL_DIG1;
      D1: begin
        sel_d    = SEL_DIG1;
        dig_d[1] = MASK[1];
      end
      G2: sel_d = SEL_DIG2;
      D2: begin
        sel_d    = SEL_DIG2;
        dig_d[2] = MASK[2];
        tick_d   = (next_cnt == ON_LAST);
      end
      default: begin
        sel_d  = SEL_BLANK;
        dig_d  = 3'b111;
        tick_d = 1'b0;
      end
    endcase
  end

  assign SEL1 = sel_q[1];
  assign SEL0 = sel_q[0];
  assign DIG0 = dig_q[0];
  assign DIG1 = dig_q[1];
  assign DIG2 = dig_q[2];
  assign TICK = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with ON_CYCLES=4, GUARD_CYCLES=2
// (18-cycle frame); expected per-edge outputs are queued and checked by a separate monitor.
module tb_display_scan_controller;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [2:0] MASK;
  logic       SEL0;
  logic       SEL1;
  logic       DIG0;
  logic       DIG1;
  logic       DIG2;
  logic       TICK;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [2:0] dig;
    logic       tick;
    string      tag;
  } exp_t;

  exp_t scoreboard[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  display_scan_controller #(
    .ON_CYCLES(4),
    .GUARD_CYCLES(2),
    .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .MASK(MASK),
    .SEL0(SEL0),
    .SEL1(SEL1),
    .DIG0(DIG0),
    .DIG1(DIG1),
    .DIG2(DIG2),
    .TICK(TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Hand-derived frame table: position k (1..18) after leaving IDLE or wrapping from D2.
  task automatic frameExpect(input int k, input logic [2:0] m,
                             output logic [1:0] sel, output logic [2:0] dig,
                             output logic tick);
    sel  = 2'b11;
    dig  = 3'b111;
    tick = 1'b0;
    if (k <= 2) begin
      sel = 2'b00;
    end else if (k <= 6) begin
      sel = 2'b00;
      dig = {2'b11, m[0]};
    end else if (k <= 8) begin
      sel = 2'b10;
    end else if (k <= 12) begin
      sel = 2'b10;
      dig = {1'b1, m[1], 1'b1};
    end else if (k <= 14) begin
      sel = 2'b01;
    end else begin
      sel  = 2'b01;
      dig  = {m[2], 2'b11};
      tick = (k == 18);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] m,
                               input logic [1:0] sel, input logic [2:0] dig,
                               input logic tick, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    RST  = rst;
    EN   = en;
    MASK = m;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.dig  = dig;
    e.tick = tick;
    e.tag  = tag;
    scoreboard.push_back(e);
  endtask

  task automatic runFrame(input int kFirst, input int kLast, input logic [2:0] m,
                          input string tag);
    logic [1:0] s;
    logic [2:0] d;
    logic       t;
    for (int k = kFirst; k <= kLast; k++) begin
      frameExpect(k, m, s, d, t);
      applyStimulus(1'b0, 1'b1, m, s, d, t, $sformatf("%s_k%0d", tag, k));
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [1:0] aSel;
    logic [2:0] aDig;
    aSel = {SEL1, SEL0};
    aDig = {DIG2, DIG1, DIG0};
    vectors++;
    if (aSel !== e.sel || aDig !== e.dig || TICK !== e.tick) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d: got sel=%b dig=%b tick=%b, expected sel=%b dig=%b tick=%b",
               e.tag, e.cyc, aSel, aDig, TICK, e.sel, e.dig, e.tick);
    end
  endtask

  always @(negedge CLK) begin
    if (scoreboard.size() > 0 && scoreboard[0].cyc == cyc)
      checkOutput(scoreboard.pop_front());
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST  = 1'b1;
    EN   = 1'b0;
    MASK = 3'b000;

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 3'b000, 2'b11, 3'b111, 1'b0, "reset");

    runFrame(1, 18, 3'b000, "f1");
    runFrame(1, 18, 3'b000, "f2");
    runFrame(1, 18, 3'b000, "f3");

    runFrame(1, 18, 3'b100, "mask100");

    runFrame(1, 9, 3'b000, "enpre");
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b11, 3'b111, 1'b0, "endrop");
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b11, 3'b111, 1'b0, "enlow");
    runFrame(1, 18, 3'b000, "enrestart");

    runFrame(1, 3, 3'b000, "midmask");
    runFrame(4, 4, 3'b001, "midmask");
    runFrame(5, 10, 3'b000, "midmask");
    runFrame(11, 11, 3'b010, "midmask");
    runFrame(12, 18, 3'b000, "midmask");

    runFrame(1, 18, 3'b000, "rstpre");
    applyStimulus(1'b1, 1'b1, 3'b000, 2'b11, 3'b111, 1'b0, "rstabort");
    applyStimulus(1'b1, 1'b1, 3'b000, 2'b11, 3'b111, 1'b0, "rsthold");
    runFrame(1, 18, 3'b000, "rstrestart");

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    while (scoreboard.size() > 0) begin
      exp_t e;
      e = scoreboard.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: expected vector at cyc=%0d was never checked", e.tag, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexed scan sequencer for the three-digit 7-segment display. Drives SEL0/SEL1 of the downstream 21-to-7 segment multiplexer and produces the matching per-digit enables, so that only one digit is lit at a time. Inserts a guard (all-digits-off) interval before each digit to suppress ghosting while the multiplexer output settles. Emits a one-cycle frame pulse after each full three-digit scan.

Parameters:
ON_CYCLES, 50000, clock cycles each digit is lit (>=1, <=2^CNT_WIDTH)
GUARD_CYCLES, 500, clock cycles of all-off guard before each digit (>=1, <=2^CNT_WIDTH)
CNT_WIDTH, 16, width of the internal phase counter

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  scan enable; low = display blanked, sequencer parked
MASK  input  3  per-digit suppress; MASK[n]=1 keeps DIGn off during its lit phase (leading-zero blanking)
SEL0  output  1  multiplexer select bit 0
SEL1  output  1  multiplexer select bit 1
DIG0  output  1  digit 0 enable, active-low
DIG1  output  1  digit 1 enable, active-low
DIG2  output  1  digit 2 enable, active-low
TICK  output  1  frame-complete pulse, one cycle, active-high

Behaviour:
- One clock; reset is synchronous and active-high: CLK, RST.
- Select encoding (fixed by the multiplexer): digit 0 -> SEL1,SEL0 = 0,0 (IN00-IN06); digit 1 -> 1,0 (IN07-IN13); digit 2 -> 0,1 (IN14-IN20); 1,1 = multiplexer outputs all zero (blank).
- States: IDLE, G0, D0, G1, D1, G2, D2. Order G0->D0->G1->D1->G2->D2->G0, continuously while EN=1.
- Gn lasts exactly GUARD_CYCLES cycles; Dn lasts exactly ON_CYCLES cycles; frame = 3*(GUARD_CYCLES+ON_CYCLES) cycles.
- Counter: cleared on every state entry, increments each cycle; state advances on the edge where counter = phase length-1. No counter wrap within a phase.
- All outputs registered and reflect the state entered on the same edge.
- IDLE: SEL1,SEL0=1,1; DIG2..0=111; TICK=0.
- Gn: SEL = digit n code (selected early so data settles); DIG2..0=111.
- Dn: SEL = digit n code; DIGn = MASK[n] (0 = lit), other DIGs = 1.
- TICK=1 exactly during the last cycle of D2; 0 otherwise.
- Reset: while RST=1 state=IDLE, counter=0, outputs = IDLE values (SEL=11, DIG=111, TICK=0). RST dominates EN. Reset mid-frame aborts immediately at next edge; no partial TICK.
- EN=0 (RST=0): next edge -> IDLE, counter cleared; outputs IDLE values from that edge. Abort is immediate from any state.
- EN=1 in IDLE: next edge -> G0; scan always restarts at digit 0 with a full guard.
- MASK sampled every cycle during Dn (may change mid-phase, takes effect on next edge); MASK never alters timing or SEL.
- Never two DIG outputs low simultaneously; DIG never low in IDLE or Gn.

Test Plan:
- ON_CYCLES=4, GUARD_CYCLES=2, MASK=000, RST released with EN=1 -> edges 1-2 G0 (SEL1,SEL0=00, DIG=111), 3-6 DIG0=0, 7-8 G1 (SEL=10), 9-12 DIG1=0, 13-14 G2 (SEL=01), 15-18 DIG2=0 with TICK=1 only on cycle 18, edge 19 G0; period 18 cycles.
- Same params, run 3 frames -> exactly 3 TICK pulses 18 cycles apart; no cycle with more than one DIG low.
- MASK=100 -> SEL/TICK timing identical to first test; DIG2 stays 1 for the whole frame; DIG0, DIG1 lit as before.
- EN dropped during D1 (cycle 10) -> next edge SEL=11, DIG=111, TICK=0; EN re-raised -> next edge G0, DIG0 low 2 cycles later.
- RST asserted during D2 last cycle (with EN=1) -> next edge SEL=11, DIG=111, TICK=0 with no TICK pulse; after release scan restarts at G0.
- Defaults (ON_CYCLES=50000, GUARD_CYCLES=500) -> frame period 151500 cycles, each DIGn low for 50000 consecutive cycles.
